// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if: operation/result handshake bundle for alu_multicycle.
// master drives operations and consumes results; slave is the ALU.
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [5:0]       operation;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             trap;

  modport master (
    output in_valid, op1, op2, operation, out_ready,
    input  in_ready, out_valid, result, result_hi, zero, trap
  );

  modport slave (
    input  in_valid, op1, op2, operation, out_ready,
    output in_ready, out_valid, result, result_hi, zero, trap
  );
endinterface

// File: rtl/alu_multicycle.sv
// alu_multicycle: execute-stage ALU with valid/ready handshake.
// Single-cycle ops resolve in the accept cycle; mulu/divu iterate one bit
// per cycle (shift-add / restoring division) when ALU_MULDIV_EN is defined.
// Without ALU_MULDIV_EN, opcodes 2 and 3 trap like any illegal opcode.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic          clk,
  input logic          rst_n,
  alu_multicycle_if.slave bus
);
  localparam int SH_W = $clog2(WIDTH);

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_MULU = 6'd2;
  localparam logic [5:0] OP_DIVU = 6'd3;
  localparam logic [5:0] OP_SLL  = 6'd4;
  localparam logic [5:0] OP_SRL  = 6'd5;
  localparam logic [5:0] OP_SLTU = 6'd6;
  localparam logic [5:0] OP_AND  = 6'd7;
  localparam logic [5:0] OP_OR   = 6'd8;
  localparam logic [5:0] OP_XOR  = 6'd9;
  localparam logic [5:0] OP_NOR  = 6'd10;
  localparam logic [5:0] OP_SRA  = 6'd11;
  localparam logic [5:0] OP_SLT  = 6'd12;

  // Elaboration-time parameter sanity.
  if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("alu_multicycle: WIDTH must be a power of two >= 8");
  end
  if (CNT_W != $clog2(WIDTH) + 1) begin : g_bad_cnt
    $error("alu_multicycle: CNT_W is derived and must not be overridden");
  end

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
`else
  typedef enum logic [1:0] {IDLE, DONE} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             zero_q, zero_d;
  logic             trap_q, trap_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_legal;
  logic [SH_W-1:0]  shamt;

  assign shamt = bus.op2[SH_W-1:0];

  // Single-cycle operation set, evaluated straight off the inputs.
  always_comb begin
    alu_res   = '0;
    alu_legal = 1'b1;
    case (bus.operation)
      OP_ADD:  alu_res = bus.op1 + bus.op2;
      OP_SUB:  alu_res = bus.op1 - bus.op2;
      OP_SLL:  alu_res = bus.op1 << shamt;
      OP_SRL:  alu_res = bus.op1 >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(bus.op1) >>> shamt);
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, bus.op1 < bus.op2};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.op1) < $signed(bus.op2)};
      OP_AND:  alu_res = bus.op1 & bus.op2;
      OP_OR:   alu_res = bus.op1 | bus.op2;
      OP_XOR:  alu_res = bus.op1 ^ bus.op2;
      OP_NOR:  alu_res = ~(bus.op1 | bus.op2);
      default: alu_legal = 1'b0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  // Iterative datapath: {hi,lo} is the product accumulator during MUL and
  // the {remainder, dividend/quotient} pair during DIV. opb holds the
  // multiplicand or the divisor.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;
  logic [WIDTH:0]   div_sh, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi_nx, div_lo_nx;

  // One shift-add step and one restoring-division step per cycle.
  always_comb begin
    mul_sum                = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    {mul_hi_nx, mul_lo_nx} = {mul_sum, lo_q[WIDTH-1:1]};
    div_sh                 = {hi_q, lo_q[WIDTH-1]};
    div_diff               = div_sh - {1'b0, opb_q};
    div_ge                 = div_sh >= {1'b0, opb_q};
    div_hi_nx              = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_lo_nx              = {lo_q[WIDTH-2:0], div_ge};
  end
`endif

  // Next-state, datapath loads and result capture on entry to DONE.
  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    zero_d   = zero_q;
    trap_d   = trap_q;
`ifdef ALU_MULDIV_EN
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Default outcome: single-cycle op (or illegal, alu_res = 0).
          state_d  = DONE;
          res_d    = alu_res;
          res_hi_d = '0;
          zero_d   = (alu_res == '0);
          trap_d   = ~alu_legal;
`ifdef ALU_MULDIV_EN
          if (bus.operation == OP_MULU) begin
            state_d = MUL;
            cnt_d   = CNT_W'(WIDTH);
            hi_d    = '0;
            lo_d    = bus.op2;
            opb_d   = bus.op1;
          end else if (bus.operation == OP_DIVU) begin
            if (bus.op2 == '0) begin
              // Divide by zero: no iteration, RISC-V style all-ones quotient.
              res_d    = '1;
              res_hi_d = bus.op1;
              zero_d   = 1'b0;
              trap_d   = 1'b1;
            end else begin
              state_d = DIV;
              cnt_d   = CNT_W'(WIDTH);
              hi_d    = '0;
              lo_d    = bus.op1;
              opb_d   = bus.op2;
            end
          end
`endif
        end
      end
`ifdef ALU_MULDIV_EN
      MUL: begin
        hi_d  = mul_hi_nx;
        lo_d  = mul_lo_nx;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = DONE;
          res_d    = mul_lo_nx;
          res_hi_d = mul_hi_nx;
          zero_d   = (mul_lo_nx == '0);
          trap_d   = 1'b0;
        end
      end
      DIV: begin
        hi_d  = div_hi_nx;
        lo_d  = div_lo_nx;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = DONE;
          res_d    = div_lo_nx;
          res_hi_d = div_hi_nx;
          zero_d   = (div_lo_nx == '0);
          trap_d   = 1'b0;
        end
      end
`endif
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      res_q    <= '0;
      res_hi_q <= '0;
      zero_q   <= 1'b0;
      trap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      zero_q   <= zero_d;
      trap_q   <= trap_d;
    end
  end

`ifdef ALU_MULDIV_EN
  // Iteration counter and multiply/divide working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      opb_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      opb_q <= opb_d;
    end
  end
`endif

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = res_q;
  assign bus.result_hi = res_hi_q;
  assign bus.zero      = zero_q;
  assign bus.trap      = trap_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed + random checks of alu_multicycle against a
// plain-arithmetic reference model. Honours ALU_MULDIV_EN like the design.
module tb_alu_multicycle;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_multicycle_if #(.WIDTH(32)) bus ();

  alu_multicycle #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: what each opcode must produce, from plain arithmetic.
  function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [31:0] rh,
                                output logic t, output int lat);
    logic [63:0] p;
    r = '0; rh = '0; t = 1'b0; lat = 1;
    case (op)
      6'd0:  r = a + b;
      6'd1:  r = a - b;
`ifdef ALU_MULDIV_EN
      6'd2:  begin p = 64'(a) * 64'(b); r = p[31:0]; rh = p[63:32]; lat = 33; end
      6'd3:  if (b == 0) begin r = 32'hFFFF_FFFF; rh = a; t = 1'b1; end
             else begin r = a / b; rh = a % b; lat = 33; end
`endif
      6'd4:  r = a << b[4:0];
      6'd5:  r = a >> b[4:0];
      6'd11: r = $signed(a) >>> b[4:0];
      6'd6:  r = (a < b) ? 32'd1 : 32'd0;
      6'd12: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd7:  r = a & b;
      6'd8:  r = a | b;
      6'd9:  r = a ^ b;
      6'd10: r = ~(a | b);
      default: t = 1'b1;
    endcase
  endfunction

  // Issue one op from IDLE, measure latency, check outputs, hold under
  // backpressure, then consume. noise keeps in_valid high with junk while busy.
  task automatic do_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int hold, input bit noise);
    logic [31:0] er, eh;
    logic        et;
    int          el, lat;
    model(op, a, b, er, eh, et, el);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.operation = op; bus.op1 = a; bus.op2 = b;
    @(posedge clk); #1;
    bus.in_valid  = noise;
    bus.operation = 6'($urandom_range(0, 12));
    bus.op1 = $urandom; bus.op2 = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, el);
    check({tag, "_result"}, bus.result, er);
    check({tag, "_result_hi"}, bus.result_hi, eh);
    check({tag, "_zero"}, bus.zero, (er == 0));
    check({tag, "_trap"}, bus.trap, et);
    check({tag, "_busy"}, bus.in_ready, 0);
    repeat (hold) begin @(posedge clk); #1; end
    if (hold > 0) begin
      check({tag, "_hold_valid"}, bus.out_valid, 1);
      check({tag, "_hold_result"}, {bus.result_hi, bus.result}, {eh, er});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_consumed"}, {bus.out_valid, bus.in_ready}, 2'b01);
  endtask

  initial begin
    logic [5:0]  rop;
    logic [31:0] ra, rb;
    checks = 0; failures = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.operation = '0; bus.op1 = '0; bus.op2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", {bus.in_ready, bus.out_valid}, 2'b10);
    check("reset_data", {bus.result_hi, bus.result, bus.zero, bus.trap}, '0);
    rst_n = 1'b1;
    #1;
    check("reset_held", {bus.in_ready, bus.out_valid, bus.result, bus.zero, bus.trap}, 36'h8_0000_0000);

    do_op("add_ovf", 6'd0, 32'h7FFF_FFFF, 32'd1, 0, 1'b0);
    do_op("mulu_max", 6'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b1);
    do_op("divu_100_7", 6'd3, 32'd100, 32'd7, 0, 1'b0);
    do_op("divu_zero", 6'd3, 32'd5, 32'd0, 2, 1'b0);
    do_op("slt", 6'd12, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    do_op("sltu", 6'd6, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    do_op("sra", 6'd11, 32'h8000_0000, 32'd31, 0, 1'b0);
    do_op("srl", 6'd5, 32'h8000_0000, 32'd31, 0, 1'b0);
    do_op("sll", 6'd4, 32'h0000_0003, 32'd33, 0, 1'b0);
    do_op("sub_eq", 6'd1, 32'h1234_5678, 32'h1234_5678, 0, 1'b0);
    do_op("nor", 6'd10, 32'h0F0F_0000, 32'h0000_F0F0, 0, 1'b1);
    do_op("illegal13", 6'd13, 32'hDEAD_BEEF, 32'd1, 1, 1'b0);
    do_op("illegal63", 6'd63, 32'd1, 32'd1, 0, 1'b0);

    // Reset in the middle of a divide: abandoned at once, next op clean.
    bus.in_valid = 1'b1; bus.operation = 6'd3; bus.op1 = 32'd1000; bus.op2 = 32'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_div", {bus.out_valid, bus.in_ready, bus.result}, {2'b01, 32'd0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_no_valid", bus.out_valid, 0);
    end
    do_op("after_rst_div", 6'd3, 32'd1000, 32'd3, 0, 1'b0);

    // Randomized operations against the model.
    for (int i = 0; i < 30; i++) begin
      rop = 6'($urandom_range(0, 15));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 40));
        default: rb = $urandom;
      endcase
      do_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised multi-cycle ALU for the pipelined processor's execute stage. It covers the single-cycle ALU operation set and adds a valid/ready handshake, an iterative multiplier and divider with full double-width results, signed compare, and an illegal/divide-by-zero trap flag. The hazard unit stalls the pipeline on `in_ready`/`out_valid` while a multi-cycle operation is in flight.

## Interface
- `WIDTH`, default 32: operand and result width. Must be a power of two, ≥ 8.
- `CNT_W`, default `$clog2(WIDTH)+1`: width of the iteration counter. Derived; do not override.
- `clk` input 1: the single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: the operation on `op1`/`op2`/`operation` is valid.
- `in_ready` output 1: the block accepts an operation. High only in IDLE.
- `op1` input WIDTH: operand 1, always rs.
- `op2` input WIDTH: operand 2. For shifts, the amount is `op2[$clog2(WIDTH)-1:0]`.
- `operation` input 6: operation code (see Operation).
- `out_valid` output 1: result outputs are valid. Held until consumed.
- `out_ready` input 1: the consumer takes the result.
- `result` output WIDTH: primary result (low product, quotient, or ALU result).
- `result_hi` output WIDTH: high product or remainder. 0 for other operations.
- `zero` output 1: `result == 0`, low word only.
- `trap` output 1: illegal opcode, or divide by zero.

## Operation
- Opcodes:
  - 0 add, 1 sub (both modulo 2^WIDTH, no overflow trap).
  - 2 mulu: unsigned 2·WIDTH product, low half to `result`, high half to `result_hi`.
  - 3 divu: unsigned quotient to `result`, remainder to `result_hi`.
  - 4 sll, 5 srl, 11 sra.
  - 6 sltu (unsigned), 12 slt (signed, two's complement). Both return 1 or 0.
  - 7 and, 8 or, 9 xor, 10 nor.
- Any other opcode: `trap`=1, `result`=0, `result_hi`=0, `zero`=1.
- FSM states IDLE, MUL, DIV, DONE.
  - IDLE: `in_valid`=1 latches operands and opcode.
    - Opcodes 2 and 3 go to MUL or DIV, with the counter loaded to WIDTH.
    - Divide by zero (opcode 3, `op2`=0) goes directly to DONE with `result`=all ones, `result_hi`=`op1`, `trap`=1.
    - All other opcodes compute in the accept cycle and go to DONE.
  - MUL: shift-add, one multiplier bit per cycle. Decrement the counter; at 1, go to DONE.
  - DIV: restoring division, one quotient bit per cycle. Same counter rule.
  - DONE: `out_valid`=1 and all outputs stable. When `out_ready`=1, go to IDLE.
- `in_ready` = (state == IDLE). No accept in DONE, so there is no same-cycle hand-off.
- Operands are registered at accept. Input changes after accept have no effect.
- `in_valid` while not in IDLE is ignored. Upstream must hold the operation until `in_ready`.

## Timing
- Reset values, applied asynchronously and held until the first clock after `rst_n` rises:
  - state IDLE, counter 0.
  - `in_ready`=1, `out_valid`=0.
  - `result`=0, `result_hi`=0, `zero`=0, `trap`=0.
- Latency from the accept edge to `out_valid`:
  - 1 cycle for single-cycle ops, illegal opcodes, and divide by zero.
  - WIDTH+1 cycles for mulu and divu.
- Maximum throughput is one operation every 2 cycles (accept, then DONE with `out_ready`=1).
- Backpressure: `out_valid` and the outputs are held indefinitely while `out_ready`=0.
- Outputs are registered and update only on entry to DONE.
- Reset mid-MUL, mid-DIV, or in DONE: the operation is abandoned, and no `out_valid` is produced for it.

## Configuration
- `ALU_MULDIV_EN` defined: MUL/DIV states, the counter, and the opcode 2/3 datapaths are compiled in as described.
- `ALU_MULDIV_EN` undefined: opcodes 2 and 3 are treated as illegal (`trap`=1, result 0, 1-cycle latency). The MUL and DIV states and their datapath are absent.

## Test plan
- Reset, then add: `op1`=0x7FFFFFFF, `op2`=1 → after 1 cycle, `out_valid`=1, `result`=0x80000000, `zero`=0, `trap`=0. Verify reset values before the first accept.
- mulu: `op1`=0xFFFFFFFF, `op2`=0xFFFFFFFF (WIDTH=32) → `out_valid` exactly 33 cycles after accept, `result`=0x00000001, `result_hi`=0xFFFFFFFE. Hold `out_ready`=0 for 5 cycles and check the outputs stay stable.
- divu:
  - 100/7 → `result`=14, `result_hi`=2, latency 33.
  - divide by zero, `op1`=5, `op2`=0 → latency 1, `result`=0xFFFFFFFF, `result_hi`=5, `trap`=1.
- Compares and shifts:
  - slt with `op1`=0xFFFFFFFF, `op2`=1 → 1; sltu with the same operands → 0.
  - sra with `op1`=0x80000000, `op2`=31 → 0xFFFFFFFF.
  - srl with `op1`=0x80000000, `op2`=31 → 1.
  - sub of equal operands → `zero`=1.
- Illegal opcode 13 → `trap`=1, `result`=0.
- Drive `in_valid` during MUL and check it is ignored. Assert `rst_n` low mid-DIV → `out_valid` 0, `in_ready` 1 immediately, and the next op completes correctly.
- With `ALU_MULDIV_EN` undefined, opcode 2 → 1-cycle `trap`=1.
